uart_apb_regfile_p: RTL and testbench

UART_APB_REGFILE_P -- requirements
Module: uart_apb_regfile_p
Interface
REQ-001 FIFO_DEPTH, 16, FIFO entries (power of 2, 4..256); CNT_W = clog2(FIFO_DEPTH)+1.
REQ-002 DIV_W, 16, baud divisor width (16 or 24).
REQ-003 PCLK  in  1  sole clock, all logic rising-edge.
REQ-004 PRESETn  in  1  synchronous, active-low reset.
REQ-005 PSEL  in  1  APB select.
REQ-006 PENABLE  in  1  APB access phase.
REQ-007 PWRITE  in  1  APB direction (1 = write).
REQ-008 PADDR  in  5  word register index.
REQ-009 PWDATA  in  32  write data (bits 7:0 used).
REQ-010 PRDATA  out  32  read data, zero-extended byte.
REQ-011 PREADY  out  1  transfer complete.
REQ-012 PSLVERR  out  1  transfer error.
REQ-013 LCR  out  8  line control register.
REQ-014 MCR  out  5  modem control (bit 4 = loopback).
REQ-015 baud_tick  out  1  one-PCLK enable pulse per divisor period (TX and RX).
REQ-016 tx_fifo_we  out  1  push PWDATA[7:0] into TX FIFO.
REQ-017 tx_fifo_clr  out  1  TX FIFO flush pulse.
REQ-018 tx_fifo_count  in  CNT_W  TX FIFO occupancy.
REQ-019 tx_busy  in  1  shifter active.
REQ-020 rx_data  in  8  RX FIFO head.
REQ-021 rx_fifo_re  out  1  pop RX FIFO.
REQ-022 rx_fifo_clr  out  1  RX FIFO flush pulse.
REQ-023 rx_fifo_count  in  CNT_W  RX FIFO occupancy.
REQ-024 rx_err  in  4  {break, framing, parity, overrun}, one-cycle flags.
REQ-025 time_out  in  1  RX character timeout.
REQ-026 irq  out  1  registered interrupt request.
Function
REQ-027 Map: 0 DR (R pop / W push), 1 IER[3:0], 2 IIR (R) / FCR (W), 3 LCR, 4 MCR, 5 LSR (RO), 7/8/11 DIV byte 0/1/2 (11 only when DIV_W=24), 9 RXTHR, 10 TXTHR; any other index or LSR write -> PSLVERR=1, no side effect.
REQ-028 APB: zero wait states; PREADY = PSEL&PENABLE; PSLVERR valid only in that cycle; write and read side effects commit at the edge ending the access phase, exactly once per transfer.
REQ-029 DR write -> tx_fifo_we high one cycle after the access; if tx_fifo_count==FIFO_DEPTH, no push and PSLVERR=1.
REQ-030 DR read returns rx_data combinationally; rx_fifo_re pulses one cycle after; suppressed when rx_fifo_count==0 (returns 0).
REQ-031 FCR write: bit1 -> rx_fifo_clr, bit2 -> tx_fifo_clr, each a one-cycle pulse; bits 7:0 stored.
REQ-032 LSR = {err_any, txfifo_empty & ~tx_busy, txfifo_empty, sticky[3:0], rx_count!=0}; sticky ORs rx_err every cycle; LSR read clears sticky; a set in the same cycle as the clear wins.
REQ-033 rx_int = rx_fifo_count >= max(RXTHR,1), saturating at FIFO_DEPTH.
REQ-034 tx_int sets on the cycle tx_fifo_count transitions from >TXTHR to <=TXTHR; clears on IIR read returning 0x2 or on DR write; set wins over clear.
REQ-035 IIR priority: ls&IER2 ->0x6, rx&IER0 ->0x4, time_out&IER3 ->0xC, tx&IER1 ->0x2, else 0x1; PRDATA[7:6]=2'b11.
REQ-036 irq = OR of enabled sources, registered, one-cycle latency; forced 0 for the cycle after an IIR read.
REQ-037 Baud: any DIV byte write reloads counter to DIVISOR-1; count down; at 0, baud_tick=1 for one cycle and reload; DIVISOR==0 -> baud_tick held 0; DIVISOR==1 -> tick every cycle.
Reset
REQ-038 PRESETn low at a clock edge: PRDATA-side regs, LCR, MCR, IER, DIVISOR, sticky, tx_int, irq, baud_tick, all pulses = 0; IIR=0x1; FCR=0xC0; RXTHR=1; TXTHR=0; an in-flight transfer is dropped with no side effect.
Structure
REQ-039 Package uart_regfile_pkg holds register indices, IIR codes, and the FCR/LSR bit positions.
REQ-040 One sub-module, uart_baud_gen (DIV_W parameter, reload, tick).
Verification
REQ-041 Write DIV0=0x04, DIV1=0x00 -> baud_tick every 4th PCLK; DIV=0 -> no tick for 100 cycles.
REQ-042 RXTHR=8, IER=0x1, rx_fifo_count 7->8 -> irq=1 next cycle, IIR read = 0xC4.
REQ-043 IER=0x2, TXTHR=2, tx count 3->2 -> irq; IIR read 0xC2 -> irq=0 and tx_int cleared.
REQ-044 rx_err=4'b0010 pulse plus LSR read in the same cycle -> sticky stays set; second LSR read clears it.
REQ-045 DR read with count 0, write to PADDR 0x0C, TX DR write when full -> PSLVERR=1 each time, no pulses.
REQ-046 Reset asserted during ACCESS of an LCR write -> LCR=0, no tx_fifo_we, IIR=0x1.

---
 rtl/uart_regfile_pkg.sv | 38 +++
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_apb_regfile_p.sv | 191 +++++++++++++++++++
 tb/tb_uart_apb_regfile_p.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_regfile_pkg.sv
// Shared register map, interrupt identification codes and FCR/LSR bit positions
// for the UART APB register file.
package uart_regfile_pkg;

  localparam logic [4:0] REG_DR    = 5'd0;
  localparam logic [4:0] REG_IER   = 5'd1;
  localparam logic [4:0] REG_IIR   = 5'd2;
  localparam logic [4:0] REG_FCR   = 5'd2;
  localparam logic [4:0] REG_LCR   = 5'd3;
  localparam logic [4:0] REG_MCR   = 5'd4;
  localparam logic [4:0] REG_LSR   = 5'd5;
  localparam logic [4:0] REG_DIV0  = 5'd7;
  localparam logic [4:0] REG_DIV1  = 5'd8;
  localparam logic [4:0] REG_RXTHR = 5'd9;
  localparam logic [4:0] REG_TXTHR = 5'd10;
  localparam logic [4:0] REG_DIV2  = 5'd11;

  typedef enum logic [3:0] {
    IIR_NONE = 4'h1,
    IIR_TX   = 4'h2,
    IIR_RX   = 4'h4,
    IIR_LS   = 4'h6,
    IIR_TO   = 4'hC
  } iir_code_e;

  localparam logic [1:0] IIR_FIFO_EN = 2'b11;

  localparam int         FCR_RX_CLR = 1;
  localparam int         FCR_TX_CLR = 2;
  localparam logic [7:0] FCR_RESET  = 8'hC0;

  localparam int LSR_DR      = 0;
  localparam int LSR_ERR_LO  = 1;
  localparam int LSR_THRE    = 5;
  localparam int LSR_TEMT    = 6;
  localparam int LSR_ERR_ANY = 7;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-rate enable generator: down-counter reloaded to divisor-1, one-cycle tick
// at terminal count. A zero divisor parks the generator with no ticks.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [DIV_W-1:0] divisor,
  input  logic             reload,
  output logic             baud_tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      cnt       <= '0;
      baud_tick <= 1'b0;
    end else if (divisor == '0) begin
      cnt       <= '0;
      baud_tick <= 1'b0;
    end else if (reload) begin
      cnt       <= divisor - DIV_W'(1);
      baud_tick <= 1'b0;
    end else if (cnt == '0) begin
      cnt       <= divisor - DIV_W'(1);
      baud_tick <= 1'b1;
    end else begin
      cnt       <= cnt - DIV_W'(1);
      baud_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_apb_regfile_p.sv
// APB register file for a 16550-style UART: register decode, FIFO strobes,
// line status tracking, interrupt identification and the baud generator.
module uart_apb_regfile_p
  import uart_regfile_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  parameter  int DIV_W      = 16,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [4:0]       PADDR,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  output logic [7:0]       LCR,
  output logic [4:0]       MCR,
  output logic             baud_tick,
  output logic             tx_fifo_we,
  output logic             tx_fifo_clr,
  input  logic [CNT_W-1:0] tx_fifo_count,
  input  logic             tx_busy,
  input  logic [7:0]       rx_data,
  output logic             rx_fifo_re,
  output logic             rx_fifo_clr,
  input  logic [CNT_W-1:0] rx_fifo_count,
  input  logic [3:0]       rx_err,
  input  logic             time_out,
  output logic             irq
);

  logic             access, wr_ok, rd_ok, addr_ok, err;
  logic             tx_full, tx_empty, rx_empty;
  logic [3:0]       ier_q, sticky_q;
  logic [7:0]       fcr_q, rxthr_q, txthr_q, lsr, rdata;
  logic [23:0]      div_q;
  logic             div_reload_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic             tx_int_q, tx_set, tx_clr, rx_int, ls_int;
  logic             lsr_rd, iir_rd, irq_src;
  logic [8:0]       rx_thr;
  iir_code_e        iir_code;

  assign access   = PSEL & PENABLE;
  assign PREADY   = access;
  assign tx_full  = (tx_fifo_count == CNT_W'(FIFO_DEPTH));
  assign tx_empty = (tx_fifo_count == '0);
  assign rx_empty = (rx_fifo_count == '0);

  always_comb begin
    addr_ok = 1'b0;
    case (PADDR)
      REG_DR, REG_IER, REG_IIR, REG_LCR, REG_MCR, REG_LSR,
      REG_DIV0, REG_DIV1, REG_RXTHR, REG_TXTHR: addr_ok = 1'b1;
      REG_DIV2: addr_ok = (DIV_W == 24);
      default:  addr_ok = 1'b0;
    endcase
  end

  // Full TX FIFO on push and empty RX FIFO on pop are reported as errors.
  assign err = ~addr_ok
             | ( PWRITE & (PADDR == REG_LSR))
             | ( PWRITE & (PADDR == REG_DR) & tx_full)
             | (~PWRITE & (PADDR == REG_DR) & rx_empty);

  assign PSLVERR = access & err;
  assign wr_ok   = access &  PWRITE & ~err;
  assign rd_ok   = access & ~PWRITE & ~err;
  assign lsr_rd  = rd_ok & (PADDR == REG_LSR);
  assign iir_rd  = rd_ok & (PADDR == REG_IIR);

  always_comb begin
    rx_thr = {1'b0, rxthr_q};
    if (rxthr_q == 8'd0)
      rx_thr = 9'd1;
    else if (rx_thr > 9'(FIFO_DEPTH))
      rx_thr = 9'(FIFO_DEPTH);
  end

  assign rx_int = (9'(rx_fifo_count) >= rx_thr);
  assign ls_int = |sticky_q;
  assign tx_set = (9'(tx_cnt_q) > {1'b0, txthr_q}) && (9'(tx_fifo_count) <= {1'b0, txthr_q});

  always_comb begin
    iir_code = IIR_NONE;
    if (ls_int & ier_q[2])
      iir_code = IIR_LS;
    else if (rx_int & ier_q[0])
      iir_code = IIR_RX;
    else if (time_out & ier_q[3])
      iir_code = IIR_TO;
    else if (tx_int_q & ier_q[1])
      iir_code = IIR_TX;
  end

  assign tx_clr  = (iir_rd & (iir_code == IIR_TX)) | (wr_ok & (PADDR == REG_DR));
  assign irq_src = (ls_int & ier_q[2]) | (rx_int & ier_q[0])
                 | (time_out & ier_q[3]) | (tx_int_q & ier_q[1]);

  always_comb begin
    lsr                        = '0;
    lsr[LSR_DR]                = ~rx_empty;
    lsr[LSR_ERR_LO +: 4]       = sticky_q;
    lsr[LSR_THRE]              = tx_empty;
    lsr[LSR_TEMT]              = tx_empty & ~tx_busy;
    lsr[LSR_ERR_ANY]           = ls_int;
  end

  always_comb begin
    rdata = '0;
    case (PADDR)
      REG_DR:    rdata = rx_empty ? 8'd0 : rx_data;
      REG_IER:   rdata = {4'd0, ier_q};
      REG_IIR:   rdata = {IIR_FIFO_EN, 2'b00, iir_code};
      REG_LCR:   rdata = LCR;
      REG_MCR:   rdata = {3'd0, MCR};
      REG_LSR:   rdata = lsr;
      REG_DIV0:  rdata = div_q[7:0];
      REG_DIV1:  rdata = div_q[15:8];
      REG_DIV2:  rdata = div_q[23:16];
      REG_RXTHR: rdata = rxthr_q;
      REG_TXTHR: rdata = txthr_q;
      default:   rdata = '0;
    endcase
  end

  assign PRDATA = {24'd0, rdata};

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      ier_q        <= '0;
      fcr_q        <= FCR_RESET;
      LCR          <= '0;
      MCR          <= '0;
      div_q        <= '0;
      rxthr_q      <= 8'd1;
      txthr_q      <= 8'd0;
      sticky_q     <= '0;
      tx_cnt_q     <= '0;
      tx_int_q     <= 1'b0;
      irq          <= 1'b0;
      div_reload_q <= 1'b0;
      tx_fifo_we   <= 1'b0;
      rx_fifo_re   <= 1'b0;
      tx_fifo_clr  <= 1'b0;
      rx_fifo_clr  <= 1'b0;
    end else begin
      tx_fifo_we   <= wr_ok & (PADDR == REG_DR);
      rx_fifo_re   <= rd_ok & (PADDR == REG_DR);
      rx_fifo_clr  <= wr_ok & (PADDR == REG_FCR) & PWDATA[FCR_RX_CLR];
      tx_fifo_clr  <= wr_ok & (PADDR == REG_FCR) & PWDATA[FCR_TX_CLR];
      div_reload_q <= wr_ok & ((PADDR == REG_DIV0) | (PADDR == REG_DIV1) | (PADDR == REG_DIV2));
      if (wr_ok) begin
        case (PADDR)
          REG_IER:   ier_q         <= PWDATA[3:0];
          REG_FCR:   fcr_q         <= PWDATA[7:0];
          REG_LCR:   LCR           <= PWDATA[7:0];
          REG_MCR:   MCR           <= PWDATA[4:0];
          REG_DIV0:  div_q[7:0]    <= PWDATA[7:0];
          REG_DIV1:  div_q[15:8]   <= PWDATA[7:0];
          REG_DIV2:  div_q[23:16]  <= PWDATA[7:0];
          REG_RXTHR: rxthr_q       <= PWDATA[7:0];
          REG_TXTHR: txthr_q       <= PWDATA[7:0];
          default: ;
        endcase
      end
      // A new error flag arriving with the LSR read survives the clear.
      sticky_q <= (lsr_rd ? 4'd0 : sticky_q) | rx_err;
      tx_cnt_q <= tx_fifo_count;
      tx_int_q <= tx_set | (tx_int_q & ~tx_clr);
      irq      <= iir_rd ? 1'b0 : irq_src;
    end
  end

  // Reload is delayed a cycle so the generator sees the freshly written byte.
  uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .divisor   (div_q[DIV_W-1:0]),
    .reload    (div_reload_q),
    .baud_tick (baud_tick)
  );

  logic unused_ok;
  assign unused_ok = ^{PWDATA[31:8], fcr_q};

endmodule

// File: tb/tb_uart_apb_regfile_p.sv
// Self-checking bench for uart_apb_regfile_p: vector table for decode/strobes,
// directed interrupt, status, baud and reset sequences, randomized model checks.
module tb_uart_apb_regfile_p;
  import uart_regfile_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [4:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [7:0]  LCR;
  logic [4:0]  MCR;
  logic        baud_tick, tx_fifo_we, tx_fifo_clr, rx_fifo_re, rx_fifo_clr, irq;
  logic [CNT_W-1:0] tx_fifo_count = '0, rx_fifo_count = '0;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [3:0]  rx_err = '0;
  logic        time_out = 1'b0;
  logic [3:0]  acc_err = '0;

  int errors = 0;
  int checks = 0;

  always #5 PCLK = ~PCLK;

  uart_apb_regfile_p #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .LCR(LCR), .MCR(MCR), .baud_tick(baud_tick), .tx_fifo_we(tx_fifo_we),
    .tx_fifo_clr(tx_fifo_clr), .tx_fifo_count(tx_fifo_count), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_fifo_re(rx_fifo_re), .rx_fifo_clr(rx_fifo_clr),
    .rx_fifo_count(rx_fifo_count), .rx_err(rx_err), .time_out(time_out), .irq(irq)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // pulses = {tx_fifo_we, rx_fifo_re, tx_fifo_clr, rx_fifo_clr} in the cycle after the access
  task automatic apb(input logic w, input logic [4:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err, output logic [3:0] pulses);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    #1 chk("pready_setup", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1; rx_err = acc_err;
    #1;
    rd = PRDATA; err = PSLVERR;
    chk("pready_access", 32'(PREADY), 32'd1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; rx_err = '0;
    pulses = {tx_fifo_we, rx_fifo_re, tx_fifo_clr, rx_fifo_clr};
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    logic [31:0] r; logic e; logic [3:0] p;
    apb(1'b1, a, {24'd0, d}, r, e, p);
    chk($sformatf("wr_err_a%0d", a), 32'(e), 32'd0);
    chk($sformatf("wr_no_re_a%0d", a), 32'(p[2]), 32'd0);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] data);
    logic e; logic [3:0] p;
    apb(1'b0, a, 32'd0, data, e, p);
    chk($sformatf("rd_err_a%0d", a), 32'(e), 32'd0);
    chk($sformatf("rd_no_we_a%0d", a), 32'(p[3]), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge PCLK); #1;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    tx_fifo_count = '0; rx_fifo_count = '0; rx_err = '0; time_out = 1'b0;
    tx_busy = 1'b0; acc_err = '0;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
  endtask

  task automatic reset_in_access(input logic [4:0] a, input logic [7:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = {24'd0, d};
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESETn = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    chk($sformatf("rst_acc_we_a%0d", a), 32'(tx_fifo_we), 32'd0);
    chk($sformatf("rst_acc_lcr_a%0d", a), 32'(LCR), 32'd0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk($sformatf("rst_acc_we2_a%0d", a), 32'(tx_fifo_we), 32'd0);
    chk($sformatf("rst_acc_lcr2_a%0d", a), 32'(LCR), 32'd0);
  endtask

  typedef struct {
    logic       w;
    logic [4:0] a;
    logic [7:0] d;
    logic [4:0] txc;
    logic [4:0] rxc;
    logic [7:0] rxd;
    logic [7:0] exp_rd;
    logic       exp_err;
    logic [3:0] exp_p;
  } vec_t;

  vec_t vecs[15];

  function automatic int rx_eff_thr(input int thr);
    int t;
    t = (thr == 0) ? 1 : thr;
    return (t > DEPTH) ? DEPTH : t;
  endfunction

  initial begin
    logic [31:0] r;
    logic        e;
    logic [3:0]  p;
    int          ticks, bad_gap, last;
    logic [7:0]  mdl[16];
    logic [4:0]  rw_addr[7];
    logic [7:0]  rw_mask[7];

    // w  addr        data   txc    rxc    rxd    exp_rd err  pulses{we,re,tclr,rclr}
    vecs[0]  = '{1'b1, REG_DR,    8'h41, 5'd5,  5'd0, 8'h00, 8'h00, 1'b0, 4'b1000};
    vecs[1]  = '{1'b1, REG_DR,    8'h42, 5'd16, 5'd0, 8'h00, 8'h00, 1'b1, 4'b0000};
    vecs[2]  = '{1'b0, REG_DR,    8'h00, 5'd0,  5'd3, 8'hA5, 8'hA5, 1'b0, 4'b0100};
    vecs[3]  = '{1'b0, REG_DR,    8'h00, 5'd0,  5'd0, 8'h5A, 8'h00, 1'b1, 4'b0000};
    vecs[4]  = '{1'b1, 5'h0C,     8'h77, 5'd0,  5'd0, 8'h00, 8'h00, 1'b1, 4'b0000};
    vecs[5]  = '{1'b1, REG_LSR,   8'hFF, 5'd0,  5'd0, 8'h00, 8'h00, 1'b1, 4'b0000};
    vecs[6]  = '{1'b0, 5'd6,      8'h00, 5'd0,  5'd0, 8'h00, 8'h00, 1'b1, 4'b0000};
    vecs[7]  = '{1'b0, REG_DIV2,  8'h00, 5'd0,  5'd0, 8'h00, 8'h00, 1'b1, 4'b0000};
    vecs[8]  = '{1'b1, REG_FCR,   8'h06, 5'd0,  5'd0, 8'h00, 8'h00, 1'b0, 4'b0011};
    vecs[9]  = '{1'b1, REG_FCR,   8'h02, 5'd0,  5'd0, 8'h00, 8'h00, 1'b0, 4'b0001};
    vecs[10] = '{1'b1, REG_FCR,   8'h04, 5'd0,  5'd0, 8'h00, 8'h00, 1'b0, 4'b0010};
    vecs[11] = '{1'b0, REG_LSR,   8'h00, 5'd0,  5'd2, 8'h00, 8'h61, 1'b0, 4'b0000};
    vecs[12] = '{1'b0, REG_LSR,   8'h00, 5'd3,  5'd0, 8'h00, 8'h00, 1'b0, 4'b0000};
    vecs[13] = '{1'b1, REG_IER,   8'h3C, 5'd0,  5'd0, 8'h00, 8'h00, 1'b0, 4'b0000};
    vecs[14] = '{1'b0, REG_IER,   8'h00, 5'd0,  5'd0, 8'h00, 8'h0C, 1'b0, 4'b0000};

    // Reset state
    do_reset();
    chk("rst_lcr", 32'(LCR), 32'd0);
    chk("rst_mcr", 32'(MCR), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_tick", 32'(baud_tick), 32'd0);
    chk("rst_pulses", 32'({tx_fifo_we, rx_fifo_re, tx_fifo_clr, rx_fifo_clr}), 32'd0);
    rd(REG_IIR, r);   chk("rst_iir", r, 32'hC1);
    rd(REG_RXTHR, r); chk("rst_rxthr", r, 32'h01);
    rd(REG_TXTHR, r); chk("rst_txthr", r, 32'h00);
    rd(REG_IER, r);   chk("rst_ier", r, 32'h00);
    rd(REG_DIV0, r);  chk("rst_div0", r, 32'h00);

    // Decode, error and strobe vectors
    for (int i = 0; i < 15; i++) begin
      tx_fifo_count = vecs[i].txc;
      rx_fifo_count = vecs[i].rxc;
      rx_data       = vecs[i].rxd;
      apb(vecs[i].w, vecs[i].a, {24'd0, vecs[i].d}, r, e, p);
      if (!vecs[i].w) chk($sformatf("vec%0d_rdata", i), r, {24'd0, vecs[i].exp_rd});
      chk($sformatf("vec%0d_slverr", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_pulses", i), 32'(p), 32'(vecs[i].exp_p));
      @(posedge PCLK); #1;
      chk($sformatf("vec%0d_pulse_once", i),
          32'({tx_fifo_we, rx_fifo_re, tx_fifo_clr, rx_fifo_clr}), 32'd0);
    end

    // RX threshold interrupt
    do_reset();
    wr(REG_IER, 8'h01);
    wr(REG_RXTHR, 8'd8);
    rx_fifo_count = 5'd7;
    repeat (2) @(posedge PCLK);
    #1 chk("rx_irq_below", 32'(irq), 32'd0);
    rx_fifo_count = 5'd8;
    @(posedge PCLK); #1;
    chk("rx_irq_set", 32'(irq), 32'd1);
    rd(REG_IIR, r);
    chk("rx_iir", r, 32'hC4);
    chk("rx_irq_forced_low", 32'(irq), 32'd0);
    @(posedge PCLK); #1;
    chk("rx_irq_back", 32'(irq), 32'd1);

    // TX threshold interrupt, cleared by IIR read and by DR write
    do_reset();
    wr(REG_IER, 8'h02);
    wr(REG_TXTHR, 8'd2);
    tx_fifo_count = 5'd3;
    repeat (2) @(posedge PCLK);
    #1 chk("tx_irq_above", 32'(irq), 32'd0);
    tx_fifo_count = 5'd2;
    repeat (2) @(posedge PCLK);
    #1 chk("tx_irq_set", 32'(irq), 32'd1);
    rd(REG_IIR, r);
    chk("tx_iir", r, 32'hC2);
    chk("tx_irq_after_read", 32'(irq), 32'd0);
    repeat (3) @(posedge PCLK);
    #1 chk("tx_irq_stays_low", 32'(irq), 32'd0);
    rd(REG_IIR, r);
    chk("tx_iir_cleared", r, 32'hC1);
    tx_fifo_count = 5'd3;
    repeat (2) @(posedge PCLK);
    #1 tx_fifo_count = 5'd2;
    repeat (2) @(posedge PCLK);
    #1 chk("tx_irq_set2", 32'(irq), 32'd1);
    wr(REG_DR, 8'h55);
    @(posedge PCLK); #1;
    chk("tx_irq_dr_clear", 32'(irq), 32'd0);
    rd(REG_IIR, r);
    chk("tx_iir_dr_cleared", r, 32'hC1);

    // Sticky line status vs. LSR read, and IIR priority
    do_reset();
    acc_err = 4'b0010;
    rd(REG_LSR, r); chk("lsr_first", r, 32'h60);
    acc_err = 4'b0000;
    rd(REG_LSR, r); chk("lsr_sticky_kept", r, 32'hE4);
    rd(REG_LSR, r); chk("lsr_cleared", r, 32'h60);
    wr(REG_IER, 8'h0F);
    time_out = 1'b1;
    rd(REG_IIR, r); chk("prio_timeout", r, 32'hCC);
    rx_fifo_count = 5'd1;
    rd(REG_IIR, r); chk("prio_rx_over_to", r, 32'hC4);
    @(posedge PCLK); #1 rx_err = 4'b0001;
    @(posedge PCLK); #1 rx_err = 4'b0000;
    rd(REG_IIR, r); chk("prio_ls_top", r, 32'hC6);
    rd(REG_LSR, r); chk("lsr_overrun", r, 32'hE3);
    rd(REG_IIR, r); chk("prio_after_ls_clear", r, 32'hC4);
    time_out = 1'b0; rx_fifo_count = '0;

    // Reset during the access phase drops the transfer
    do_reset();
    wr(REG_LCR, 8'h03);
    chk("lcr_written", 32'(LCR), 32'h03);
    reset_in_access(REG_LCR, 8'h1B);
    rd(REG_IIR, r); chk("rst_acc_iir", r, 32'hC1);
    reset_in_access(REG_DR, 8'hA7);

    // Baud generator
    do_reset();
    wr(REG_DIV0, 8'h04);
    wr(REG_DIV1, 8'h00);
    repeat (3) @(posedge PCLK);
    ticks = 0; bad_gap = 0; last = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge PCLK); #1;
      if (baud_tick) begin
        if (last >= 0 && (c - last) != 4) bad_gap++;
        last = c; ticks++;
      end
    end
    chk("baud4_ticks", 32'(ticks), 32'd10);
    chk("baud4_gaps", 32'(bad_gap), 32'd0);
    wr(REG_DIV0, 8'h01);
    repeat (3) @(posedge PCLK);
    ticks = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge PCLK); #1;
      if (baud_tick) ticks++;
    end
    chk("baud1_ticks", 32'(ticks), 32'd20);
    wr(REG_DIV0, 8'h00);
    @(posedge PCLK);
    ticks = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge PCLK); #1;
      if (baud_tick) ticks++;
    end
    chk("baud0_ticks", 32'(ticks), 32'd0);

    // Randomized register write/readback against an array model
    do_reset();
    rw_addr = '{REG_IER, REG_LCR, REG_MCR, REG_DIV0, REG_DIV1, REG_RXTHR, REG_TXTHR};
    rw_mask = '{8'h0F, 8'hFF, 8'h1F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    foreach (mdl[k]) mdl[k] = 8'h00;
    mdl[REG_RXTHR] = 8'h01;
    for (int i = 0; i < 30; i++) begin
      int wi, ri;
      logic [7:0] dv;
      wi = $urandom_range(0, 6);
      ri = $urandom_range(0, 6);
      dv = 8'($urandom);
      wr(rw_addr[wi], dv);
      mdl[rw_addr[wi]] = dv & rw_mask[wi];
      rd(rw_addr[ri], r);
      chk($sformatf("rand_rb%0d_a%0d", i, rw_addr[ri]), r, {24'd0, mdl[rw_addr[ri]]});
    end
    chk("rand_lcr_port", 32'(LCR), 32'(mdl[REG_LCR]));
    chk("rand_mcr_port", 32'(MCR), 32'(mdl[REG_MCR]));

    // Randomized RX threshold against the saturating-threshold rule
    do_reset();
    wr(REG_IER, 8'h01);
    for (int i = 0; i < 20; i++) begin
      int thr, cnt;
      logic exp_int;
      thr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 255));
      cnt = $urandom_range(0, DEPTH);
      wr(REG_RXTHR, 8'(thr));
      rx_fifo_count = 5'(cnt);
      repeat (2) @(posedge PCLK);
      #1;
      exp_int = (cnt >= rx_eff_thr(thr));
      chk($sformatf("rand_rx_irq_t%0d_c%0d", thr, cnt), 32'(irq), 32'(exp_int));
      rd(REG_IIR, r);
      chk($sformatf("rand_rx_iir_t%0d_c%0d", thr, cnt), r, exp_int ? 32'hC4 : 32'hC1);
    end
    rx_fifo_count = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
